mul4_tournament_sequencer: RTL
==============================

Name: mul4_tournament_sequencer

Overview:
- Sequential fitness evaluator for two candidate 2x16-bit vector multipliers, evaluated in tournament pairs.
- Drives one shared pseudo-random operand stream into both candidates and samples their 4x16-bit outputs each cycle.
- Scores each output word against a golden 32x32 product, then reports per-candidate scores and a winner.
- Sits between the tournament controller and the combinational candidate individuals.

Parameters:
- NUM_VECTORS, 64, operand vectors per evaluation; must be at least 1.
- SEED_A, 32'hACE1_2468, initial state of the A-operand LFSR; nonzero, elaboration-time assertion.
- SEED_B, 32'h1357_BEEF, initial state of the B-operand LFSR; nonzero, elaboration-time assertion.
- SCORE_W, $clog2(4*NUM_VECTORS+1), score width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request an evaluation; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; scores and winner are valid from this cycle.
- a1, a0, b1, b0  out  16 each  operands to both candidates.
- c0_y  in  64  candidate 0 result {y3,y2,y1,y0}, combinational from the operands.
- c1_y  in  64  candidate 1 result, same packing.
- score0, score1  out  SCORE_W  matching-word count per candidate.
- winner  out  1  0 = candidate 0, 1 = candidate 1.
- perfect0, perfect1  out  1  score equals 4*NUM_VECTORS.

Behaviour:
- Reset (asynchronous, active-low, any state including mid-run):
  - State goes to IDLE; busy=0, done=0.
  - Operand outputs, scores, winner and perfect flags go to 0.
  - LFSRs load SEED_A and SEED_B; vector counter=0; pipeline valid bit=0.
- Golden function: {y3,y2,y1,y0} = {a1,a0} * {b1,b0}, unsigned, 64-bit result.
- LFSRs:
  - Two 32-bit Galois LFSRs, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), shift right.
  - Both step once per DRIVE cycle.
  - {a1,a0} = LFSR_A state and {b1,b0} = LFSR_B state, registered outputs.
- FSM states: IDLE, DRIVE, DRAIN, DONE.
  - IDLE, start=1: reload both LFSRs with their seeds, clear the scores and counter. Next state DRIVE; busy=1 from that cycle.
  - DRIVE: the operands hold vector k. Stage 1 registers the operands, c0_y and c1_y, and sets the valid bit. The counter increments and the LFSRs step. After NUM_VECTORS cycles the next state is DRAIN. Operands are not updated after the last vector.
  - DRAIN: one cycle in which stage 2 consumes the final captured vector. Next state DONE.
  - DONE: done=1 for one cycle; score, winner and perfect outputs are updated. Next state IDLE; busy=0 from the cycle after DONE.
- Stage 2, every cycle while valid=1:
  - Compute the golden product of the captured operands.
  - Add to each score the number of the 4 result words exactly equal to the golden words (0..4).
  - Scores saturate at 4*NUM_VECTORS; saturation is unreachable by construction but is checked by assertion.
- Latency: start accepted at cycle t gives done=1 at cycle t+NUM_VECTORS+2.
- Winner rule: winner = (score1 > score0); a tie goes to candidate 0.
- Output holding: score0/score1/winner/perfect hold their values until the next accepted start, where they clear.
- start while busy or in DONE: ignored, with no effect on the run.
- start in the cycle after DONE (IDLE): accepted normally.
- Candidate outputs are sampled in the same cycle the operands are presented. Candidates must be combinational, and timing closes through the candidate logic.

Decomposition:
- Package mul4_tournament_pkg:
  - state enum;
  - LFSR mask constant;
  - function lfsr_step(logic [31:0]);
  - function word_hits(golden, cand) returning 3 bits.
- One sub-module: mul4_golden_model, combinational 32x32 to 64 unsigned multiply with the same port packing as a candidate. It is instantiated in stage 2.

Test Plan:
- Both candidates = mul4_golden_model, NUM_VECTORS=64 -> done at t+66, score0=score1=256, perfect0=perfect1=1, winner=0.
- c0 = golden, c1 = golden with y0[0] inverted -> score0=256, score1=192, winner=0, perfect1=0.
- c0 tied to 64'h0, c1 = golden -> score1=256, winner=1, perfect1=1; score0 equals the bench model's count of zero product words.
- First DRIVE cycle -> {a1,a0}=32'hACE1_2468, {b1,b0}=32'h1357_BEEF; second cycle equals lfsr_step of each seed.
- NUM_VECTORS=1, start at cycle 5 -> done at cycle 8; start pulses at cycles 6 and 7 are ignored, with busy 1 during cycles 6-8 and no restart.
- rst_n low for 1 cycle during DRIVE vector 30, then start -> scores restart from 0; the outputs repeat the seeds; the full run reproduces the scores of an uninterrupted run.

Source files
------------

// File: rtl/mul4_tournament_pkg.sv
// Shared types and helpers for the two-candidate multiplier tournament sequencer.
package mul4_tournament_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_DRAIN, ST_DONE} state_t;

  // Galois taps for x^32+x^22+x^2+x+1, right-shifting form
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  function automatic logic [2:0] word_hits(input logic [63:0] golden, input logic [63:0] cand);
    logic [2:0] n;
    n = '0;
    for (int w = 0; w < 4; w++) n = n + 3'(golden[16*w +: 16] == cand[16*w +: 16]);
    return n;
  endfunction

endpackage

// File: rtl/mul4_golden_model.sv
// Reference 32x32->64 unsigned multiply, packed exactly like a candidate individual.
module mul4_golden_model (
  input  logic [15:0] i_a1,
  input  logic [15:0] i_a0,
  input  logic [15:0] i_b1,
  input  logic [15:0] i_b0,
  output logic [63:0] o_y
);
  assign o_y = 64'({i_a1, i_a0}) * 64'({i_b1, i_b0});
endmodule

// File: rtl/mul4_tournament_sequencer.sv
// Drives a shared LFSR operand stream into two combinational candidates and scores
// each 16-bit result word against a golden product; reports scores and a winner.
module mul4_tournament_sequencer
  import mul4_tournament_pkg::*;
#(
  parameter int unsigned  NUM_VECTORS = 64,
  parameter logic [31:0]  SEED_A      = 32'hACE1_2468,
  parameter logic [31:0]  SEED_B      = 32'h1357_BEEF,
  localparam int unsigned SCORE_W     = $clog2(4*NUM_VECTORS+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [15:0]        a1,
  output logic [15:0]        a0,
  output logic [15:0]        b1,
  output logic [15:0]        b0,
  input  logic [63:0]        c0_y,
  input  logic [63:0]        c1_y,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1,
  output logic               winner,
  output logic               perfect0,
  output logic               perfect1
);

  localparam int unsigned          CNT_W     = $clog2(NUM_VECTORS+1);
  localparam logic [CNT_W-1:0]     LAST      = CNT_W'(NUM_VECTORS-1);
  localparam logic [SCORE_W-1:0]   SCORE_MAX = SCORE_W'(4*NUM_VECTORS);

  if (NUM_VECTORS < 1) begin : g_bad_nv
    $error("NUM_VECTORS must be at least 1");
  end
  if (SEED_A == 32'h0) begin : g_bad_seed_a
    $error("SEED_A must be nonzero");
  end
  if (SEED_B == 32'h0) begin : g_bad_seed_b
    $error("SEED_B must be nonzero");
  end

  state_t r_state, w_next;
  logic   w_accept;

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_lfsr_a, r_lfsr_b, r_op_a, r_op_b;

  logic             r_vld;
  logic [31:0]      r_s1_a, r_s1_b;
  logic [1:0][63:0] r_s1_y;

  logic [63:0]              w_gold;
  logic [1:0][2:0]          w_hits;
  logic [1:0][SCORE_W:0]    w_raw;
  logic [1:0][SCORE_W-1:0]  w_sum, r_acc, r_score;
  logic                     r_winner;
  logic [1:0]               r_perfect;

  assign w_accept = (r_state == ST_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_DRIVE;
      ST_DRIVE: if (r_cnt == LAST) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);

  // Operands mirror the LFSR during a run but sit at zero out of reset;
  // the last vector is held through DRAIN/DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr_a <= SEED_A;
      r_lfsr_b <= SEED_B;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_lfsr_a <= SEED_A;
      r_lfsr_b <= SEED_B;
      r_op_a   <= SEED_A;
      r_op_b   <= SEED_B;
      r_cnt    <= '0;
    end else if (r_state == ST_DRIVE) begin
      r_lfsr_a <= lfsr_step(r_lfsr_a);
      r_lfsr_b <= lfsr_step(r_lfsr_b);
      r_cnt    <= r_cnt + CNT_W'(1);
      if (r_cnt != LAST) begin
        r_op_a <= lfsr_step(r_lfsr_a);
        r_op_b <= lfsr_step(r_lfsr_b);
      end
    end
  end

  assign {a1, a0} = r_op_a;
  assign {b1, b0} = r_op_b;

  // Stage 1: candidate results are captured in the same cycle as their operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_s1_a <= '0;
      r_s1_b <= '0;
      r_s1_y <= '0;
    end else begin
      r_vld <= (r_state == ST_DRIVE);
      if (r_state == ST_DRIVE) begin
        r_s1_a <= r_op_a;
        r_s1_b <= r_op_b;
        r_s1_y <= {c1_y, c0_y};
      end
    end
  end

  mul4_golden_model u_gold (
    .i_a1 (r_s1_a[31:16]),
    .i_a0 (r_s1_a[15:0]),
    .i_b1 (r_s1_b[31:16]),
    .i_b0 (r_s1_b[15:0]),
    .o_y  (w_gold)
  );

  for (genvar c = 0; c < 2; c++) begin : g_cand
    assign w_hits[c] = word_hits(w_gold, r_s1_y[c]);
    assign w_raw[c]  = {1'b0, r_acc[c]} + (SCORE_W+1)'(w_hits[c]);
    assign w_sum[c]  = (w_raw[c] > {1'b0, SCORE_MAX}) ? SCORE_MAX : w_raw[c][SCORE_W-1:0];

    a_no_sat: assert property (@(posedge clk) disable iff (!rst_n)
                               r_vld |-> (w_raw[c] <= {1'b0, SCORE_MAX}));
  end

  // Stage 2 accumulates; published outputs take the final sum as DRAIN
  // retires so they are already valid in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_score   <= '0;
      r_winner  <= 1'b0;
      r_perfect <= '0;
    end else if (w_accept) begin
      r_acc     <= '0;
      r_score   <= '0;
      r_winner  <= 1'b0;
      r_perfect <= '0;
    end else begin
      if (r_vld) r_acc <= w_sum;
      if (r_state == ST_DRAIN) begin
        r_score   <= w_sum;
        r_winner  <= (w_sum[1] > w_sum[0]);
        r_perfect <= {w_sum[1] == SCORE_MAX, w_sum[0] == SCORE_MAX};
      end
    end
  end

  assign score0   = r_score[0];
  assign score1   = r_score[1];
  assign winner   = r_winner;
  assign perfect0 = r_perfect[0];
  assign perfect1 = r_perfect[1];

endmodule
